alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Responder end of the processor's ALU start/ack handshake.
- The control unit pulses `start` with an opcode and two operands. This block sequences the ALU operation and returns a one-cycle `ack` with the result and flags registered.
- Single-cycle ops take a fixed 2-cycle latency. MUL uses an iterative shift-add datapath, so the control unit's wait-for-ack loop is exercised with both short and long latencies.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- start  input  1  request from control unit; sampled only in IDLE.
- alu_op  input  3  operation select, latched with start.
- opa  input  WIDTH  operand A, latched with start.
- opb  input  WIDTH  operand B, latched with start.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high in every state except IDLE.
- result  output  WIDTH  registered result; holds until the next completion.
- flags  output  4  registered {Z,N,C,V}; holds until the next completion.

Behaviour:
- Reset: one clock, asynchronous active-low reset on rst_b. Asserting rst_b at any time, including mid-MUL, forces state IDLE, ack=0, busy=0, result=0, flags=0, counter=0 and internal operand registers=0.
- States: IDLE, EXEC, MUL_ITER, DONE.
- IDLE:
  - start=1 at an edge latches alu_op/opa/opb and moves to EXEC.
  - start=0 stays in IDLE.
- EXEC:
  - Ops other than MUL: the result and flags are computed combinationally from the latched operands. They are written at this edge. Next state is DONE.
  - MUL: clears the accumulator, loads the multiplier and multiplicand shift registers, sets counter=0. Next state is MUL_ITER.
- MUL_ITER, each cycle:
  - If the multiplier LSB is 1, the accumulator gets accumulator + multiplicand (2*WIDTH bits).
  - Multiplicand shifts left 1; multiplier shifts right 1; counter increments.
  - On the cycle counter==WIDTH-1, write result/flags and go to DONE. This is exactly WIDTH iterations.
- DONE: ack=1 for exactly this one cycle; unconditional return to IDLE.
- Latency, start sampled at edge k:
  - ack is high in the cycle after edge k+1, i.e. 2 cycles for single-cycle ops.
  - For MUL, ack is high after edge k+1+WIDTH (18 cycles at WIDTH=16).
- start while busy (EXEC/MUL_ITER/DONE) is ignored; no queuing. Back-to-back start is accepted at the first IDLE cycle after DONE.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A-B, computed as A+~B+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT A.
  - 110 MUL: low WIDTH bits of the product.
  - 111 PASS B.
- Flags:
  - Z = (result==0); N = result[WIDTH-1].
  - ADD/SUB: C = carry-out of the WIDTH-bit adder (SUB: C=1 means no borrow). V = signed overflow, i.e. operand signs equal (after B inversion for SUB) and the result sign differs.
  - MUL (unsigned): C = V = (upper WIDTH bits of the product != 0).
  - Logic/NOT/PASS: C = V = 0.
- Arithmetic wraps modulo 2^WIDTH.
- result/flags change only at the DONE-entry edge and remain stable while ack=1 and afterwards.

Test Plan:
- Reset then start ADD 0x7FFF+0x0001 -> ack exactly 2 cycles after start sample; result=0x8000, flags Z=0 N=1 C=0 V=1.
- SUB 0x0005-0x0005 -> result=0x0000, Z=1 N=0 C=1 V=0. Then SUB 0x0003-0x0005 -> result=0xFFFE, N=1 C=0 V=0.
- MUL 0x0012*0x0034 -> busy for 17 cycles, ack on the 18th cycle; result=0x03A8, C=V=0. MUL 0x0100*0x0100 -> result=0x0000, Z=1, C=V=1.
- start held high continuously for 40 cycles with ADD 1+1 -> ack pulses every 3 cycles, each exactly 1 cycle wide; result=0x0002. start toggled during MUL_ITER has no effect.
- Assert rst_b low during MUL iteration 8 -> outputs immediately 0, state IDLE, no ack. The next start of XOR 0xF0F0^0x0FF0 -> result=0xFF00, N=1, C=V=0.
- Sweep all 8 opcodes with A=0xA5A5, B=0x5A5A -> ADD 0xFFFF, SUB 0x4B4B (C=1, V=1), AND 0x0000 (Z=1), OR 0xFFFF, XOR 0xFFFF, NOT 0x5A5A, PASS 0x5A5A; ack width is 1 for each op.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Responder side of the ALU start/ack handshake: latches an opcode and operands,
// runs single-cycle ops or a WIDTH-step shift-add multiply, then pulses ack.
module alu_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             ack,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL_ITER,
        DONE
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [3:0]           flags_q, flags_d;

    logic [WIDTH-1:0]     b_eff;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic [2*WIDTH-1:0]   acc_next;

    // Single-cycle datapath; SUB reuses the adder as A + ~B + 1.
    always_comb begin
        b_eff   = (op_q == OP_SUB) ? ~b_q : b_q;
        sum     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_q == OP_SUB)};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOT:  alu_res = ~a_q;
            OP_PASS: alu_res = b_q;
            default: alu_res = '0;
        endcase
    end

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = alu_op;
                    a_d     = opa;
                    b_d     = opb;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_q == OP_MUL) begin
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a_q};
                    mplier_d = b_q;
                    cnt_d    = '0;
                    state_d  = MUL_ITER;
                end else begin
                    result_d = alu_res;
                    flags_d  = {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};
                    state_d  = DONE;
                end
            end
            MUL_ITER: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Last iteration commits the product straight from the adder output.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    result_d = acc_next[WIDTH-1:0];
                    flags_d  = {(acc_next[WIDTH-1:0] == '0), acc_next[WIDTH-1],
                                (|acc_next[2*WIDTH-1:WIDTH]), (|acc_next[2*WIDTH-1:WIDTH])};
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset clears all
    // registers, including operand and multiply state, so a mid-MUL reset leaves nothing stale.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign ack    = (state_q == DONE);
    assign busy   = (state_q != IDLE);
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: latency, result/flags, ack width, held start,
// mid-multiply reset and an opcode sweep, all against hand-computed values.
module tb_alu_seq_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   alu_op = '0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         ack;
    logic         busy;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int vectors = 0;
    int miscompares = 0;
    int pulses;
    int guard;

    alu_seq_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .start  (start),
        .alu_op (alu_op),
        .opa    (opa),
        .opb    (opb),
        .ack    (ack),
        .busy   (busy),
        .result (result),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one op, wait for ack (bounded), check latency, busy span, result, flags, ack width.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic [3:0] exp_flags, input int exp_lat, input bit toggle);
        int n;
        int busy_n;
        bit got;
        n = 0;
        busy_n = 0;
        got = 1'b0;
        @(negedge clk);
        alu_op = op;
        opa    = a;
        opb    = b;
        start  = 1'b1;
        while (!got && n < 64) begin
            @(posedge clk);
            #1;
            n++;
            if (ack) got = 1'b1;
            else if (busy) busy_n++;
            if (!got && toggle) begin
                start  = n[0];
                alu_op = 3'b000;
                opa    = W'($urandom);
                opb    = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        check({tag, "_latency"}, got ? n : 0, exp_lat);
        check({tag, "_busy_cycles"}, busy_n, exp_lat - 1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_flags"}, flags, exp_flags);
        check({tag, "_busy_at_ack"}, busy, 1'b1);
        @(posedge clk);
        #1;
        check({tag, "_ack_width"}, {ack, busy}, 2'b00);
        check({tag, "_result_hold"}, result, exp_res);
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_outputs", {ack, busy, flags, result}, '0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", {ack, busy}, 2'b00);

        // flags = {Z,N,C,V}
        run_op("add_ovf",  3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 2, 1'b0);
        run_op("sub_zero", 3'b001, 16'h0005, 16'h0005, 16'h0000, 4'b1010, 2, 1'b0);
        run_op("sub_neg",  3'b001, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100, 2, 1'b0);
        run_op("mul_small", 3'b110, 16'h0012, 16'h0034, 16'h03A8, 4'b0000, 18, 1'b0);
        run_op("mul_ovf",   3'b110, 16'h0100, 16'h0100, 16'h0000, 4'b1011, 18, 1'b0);
        run_op("mul_toggle", 3'b110, 16'h0012, 16'h0034, 16'h03A8, 4'b0000, 18, 1'b1);

        // start held high: accepted every third cycle, ack one cycle wide
        @(negedge clk);
        alu_op = 3'b000;
        opa    = 16'h0001;
        opb    = 16'h0001;
        start  = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            check("held_ack_pattern", ack, (i % 3 == 2));
            if (ack) begin
                pulses++;
                check("held_result", result, 16'h0002);
            end
        end
        start = 1'b0;
        check("held_pulse_count", pulses, 13);
        guard = 0;
        while (busy && guard < 10) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("held_drain", busy, 1'b0);

        // Opcode sweep
        run_op("sw_add",  3'b000, 16'hA5A5, 16'h5A5A, 16'hFFFF, 4'b0100, 2, 1'b0);
        run_op("sw_sub",  3'b001, 16'hA5A5, 16'h5A5A, 16'h4B4B, 4'b0011, 2, 1'b0);
        run_op("sw_and",  3'b010, 16'hA5A5, 16'h5A5A, 16'h0000, 4'b1000, 2, 1'b0);
        run_op("sw_or",   3'b011, 16'hA5A5, 16'h5A5A, 16'hFFFF, 4'b0100, 2, 1'b0);
        run_op("sw_xor",  3'b100, 16'hA5A5, 16'h5A5A, 16'hFFFF, 4'b0100, 2, 1'b0);
        run_op("sw_not",  3'b101, 16'hA5A5, 16'h5A5A, 16'h5A5A, 4'b0000, 2, 1'b0);
        run_op("sw_mul",  3'b110, 16'hA5A5, 16'h5A5A, 16'h3E02, 4'b0011, 18, 1'b0);
        run_op("sw_pass", 3'b111, 16'hA5A5, 16'h5A5A, 16'h5A5A, 4'b0000, 2, 1'b0);

        // Reset during multiply iteration 8
        @(negedge clk);
        alu_op = 3'b110;
        opa    = 16'h1234;
        opb    = 16'hFFFF;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("pre_reset_busy", busy, 1'b1);
        rst_b = 1'b0;
        #1;
        check("midmul_reset_outputs", {ack, busy, flags, result}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("post_reset_quiet", {ack, busy}, 2'b00);
        end
        run_op("xor_after_reset", 3'b100, 16'hF0F0, 16'h0FF0, 16'hFF00, 4'b0100, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
